// File: rtl/gpio_irq_pkg.sv
// Shared register map, FSM encoding and STATUS layout
// for the GPIO interrupt controller.
package gpio_irq_pkg;

  localparam logic [2:0] GPIO_IRQ_PENDING = 3'd0;
  localparam logic [2:0] GPIO_IRQ_ENABLE  = 3'd1;
  localparam logic [2:0] GPIO_IRQ_CLAIM   = 3'd2;
  localparam logic [2:0] GPIO_IRQ_STATUS  = 3'd3;

  localparam int STATUS_STATE_LSB = 0;
  localparam int STATUS_ID_LSB    = 2;
  localparam int STATUS_ERR_BIT   = 8;

  localparam logic [31:0] CLAIM_VALID = 32'h8000_0000;

  typedef enum logic [1:0] {
    IRQ_IDLE,
    IRQ_ARB,
    IRQ_NOTIFY,
    IRQ_ACTIVE
  } irq_state_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_bus_t.sv
// APB3 zero-wait-state bus bundle; clock and reset
// travel with the bus.
interface apb_bus_t (
  input logic PCLK,
  input logic PRESETn
);

  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;

  modport slave (
    input  PCLK,
    input  PRESETn,
    input  PSEL,
    input  PENABLE,
    input  PWRITE,
    input  PADDR,
    input  PWDATA,
    output PRDATA,
    output PREADY
  );

  modport master (
    input  PCLK,
    input  PRESETn,
    input  PRDATA,
    input  PREADY,
    output PSEL,
    output PENABLE,
    output PWRITE,
    output PADDR,
    output PWDATA
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request
// at or after ptr, wrapping past N-1 to 0.
module rr_arbiter
  import gpio_irq_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = id_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         gnt_valid,
  output logic [W-1:0] gnt_id
);

  always_comb begin
    int j;
    j         = 0;
    gnt_valid = 1'b0;
    gnt_id    = '0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!gnt_valid && req[W'(j)]) begin
        gnt_valid = 1'b1;
        gnt_id    = W'(j);
      end
    end
  end

endmodule

// File: rtl/gpio_irq_ctrl.sv
// Latches GPIO interrupt pulses and serves them to the
// CPU one at a time through an APB claim/complete flow.
module gpio_irq_ctrl
  import gpio_irq_pkg::*;
#(
  parameter  int N_SRC = 8,
  localparam int ID_W  = id_width(N_SRC)
) (
  apb_bus_t.slave          apb_bus,
  input  logic [N_SRC-1:0] irq_i,
  output logic             irq_o
);

  logic clk;
  logic rst_n;

  assign clk   = apb_bus.PCLK;
  assign rst_n = apb_bus.PRESETn;

  logic             acc;
  logic             wr;
  logic             rd;
  logic [2:0]       idx;
  logic [N_SRC-1:0] wdata;

  assign acc   = apb_bus.PSEL & apb_bus.PENABLE;
  assign wr    = acc & apb_bus.PWRITE;
  assign rd    = acc & ~apb_bus.PWRITE;
  assign idx   = apb_bus.PADDR[4:2];
  assign wdata = apb_bus.PWDATA[N_SRC-1:0];

  assign apb_bus.PREADY = acc;

  logic unused_bits;
  assign unused_bits = ^{apb_bus.PADDR, apb_bus.PWDATA};

  logic sel_pend;
  logic sel_en;
  logic sel_claim;
  logic sel_stat;

  assign sel_pend  = (idx == GPIO_IRQ_PENDING);
  assign sel_en    = (idx == GPIO_IRQ_ENABLE);
  assign sel_claim = (idx == GPIO_IRQ_CLAIM);
  assign sel_stat  = (idx == GPIO_IRQ_STATUS);

  logic wr_pend;
  logic wr_en;
  logic wr_claim;
  logic wr_stat;
  logic rd_claim;

  assign wr_pend  = wr & sel_pend;
  assign wr_en    = wr & sel_en;
  assign wr_claim = wr & sel_claim;
  assign wr_stat  = wr & sel_stat;
  assign rd_claim = rd & sel_claim;

  irq_state_t       state;
  irq_state_t       state_n;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] pending_n;
  logic [N_SRC-1:0] enable;
  logic [N_SRC-1:0] enable_n;
  logic [ID_W-1:0]  cur_id;
  logic [ID_W-1:0]  cur_id_n;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  rr_ptr_n;
  logic             err;
  logic             err_n;
  logic             err_set;

  localparam logic [N_SRC-1:0] ONE_SRC = N_SRC'(1);

  logic             live;
  logic             claim_take;
  logic             id_match;
  logic [N_SRC-1:0] w1c;
  logic [N_SRC-1:0] claim_clr;
  logic [N_SRC-1:0] arb_req;
  logic             gnt_valid;
  logic [ID_W-1:0]  gnt_id;

  // The claimed source must still be both pending and enabled.
  assign live       = pending[cur_id] & enable[cur_id];
  assign claim_take = (state == IRQ_NOTIFY) & live & rd_claim;
  assign id_match   = (apb_bus.PWDATA[ID_W-1:0] == cur_id);
  assign w1c        = wr_pend ? wdata : '0;
  assign claim_clr  = claim_take ? (ONE_SRC << cur_id) : '0;
  assign enable_n   = wr_en ? wdata : enable;

  // Arbitrate on this cycle's effective set so a W1C
  // or disable landing in ARB is seen immediately.
  assign arb_req = pending & ~w1c & enable_n;

  // A new pulse always beats a clear of the same bit.
  assign pending_n = (pending & ~w1c & ~claim_clr) | irq_i;

  rr_arbiter #(
    .N (N_SRC)
  ) u_arb (
    .req       (arb_req),
    .ptr       (rr_ptr),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  always_comb begin
    state_n  = state;
    cur_id_n = cur_id;
    rr_ptr_n = rr_ptr;
    err_set  = 1'b0;
    unique case (state)
      IRQ_IDLE: begin
        if (|(pending & enable)) state_n = IRQ_ARB;
        if (wr_claim) err_set = 1'b1;
      end
      IRQ_ARB: begin
        if (gnt_valid) begin
          cur_id_n = gnt_id;
          state_n  = IRQ_NOTIFY;
        end else begin
          state_n  = IRQ_IDLE;
        end
        if (wr_claim) err_set = 1'b1;
      end
      IRQ_NOTIFY: begin
        if (!live) begin
          state_n = IRQ_IDLE;
        end else if (claim_take) begin
          state_n  = IRQ_ACTIVE;
          rr_ptr_n = (cur_id == ID_W'(N_SRC - 1)) ?
                     '0 : cur_id + ID_W'(1);
        end
        if (wr_claim) err_set = 1'b1;
      end
      IRQ_ACTIVE: begin
        if (wr_claim) begin
          if (id_match) state_n = IRQ_IDLE;
          else          err_set = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    err_n = err;
    if (wr_stat && apb_bus.PWDATA[STATUS_ERR_BIT])
      err_n = 1'b0;
    if (err_set) err_n = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IRQ_IDLE;
      pending <= '0;
      enable  <= '0;
      cur_id  <= '0;
      rr_ptr  <= '0;
      err     <= 1'b0;
      irq_o   <= 1'b0;
    end else begin
      state   <= state_n;
      pending <= pending_n;
      enable  <= enable_n;
      cur_id  <= cur_id_n;
      rr_ptr  <= rr_ptr_n;
      err     <= err_n;
      irq_o   <= (state_n == IRQ_NOTIFY);
    end
  end

  logic [31:0] rdata;

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      sel_pend:  rdata = 32'(pending);
      sel_en:    rdata = 32'(enable);
      sel_claim: rdata = claim_take ?
                         (CLAIM_VALID | 32'(cur_id)) : '0;
      sel_stat: begin
        rdata[STATUS_STATE_LSB +: 2]  = state;
        rdata[STATUS_ID_LSB +: ID_W] = cur_id;
        rdata[STATUS_ERR_BIT]        = err;
      end
      default: rdata = '0;
    endcase
  end

  assign apb_bus.PRDATA = rd ? rdata : '0;

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Directed bench for gpio_irq_ctrl: latency, round-robin,
// collisions, protocol errors and async reset.
module tb_gpio_irq_ctrl;

  localparam logic [2:0] R_PEND  = 3'd0;
  localparam logic [2:0] R_EN    = 3'd1;
  localparam logic [2:0] R_CLAIM = 3'd2;
  localparam logic [2:0] R_STAT  = 3'd3;

  logic       clk;
  logic       rst_n;
  logic [7:0] irq_i;
  logic       irq_o;

  int checks   = 0;
  int failures = 0;

  apb_bus_t bus (
    .PCLK    (clk),
    .PRESETn (rst_n)
  );

  gpio_irq_ctrl #(
    .N_SRC (8)
  ) dut (
    .apb_bus (bus),
    .irq_i   (irq_i),
    .irq_o   (irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic bus_idle();
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
    bus.PADDR   = '0;
    bus.PWDATA  = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    irq_i = '0;
    bus_idle();
    #3;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic apb_write(input logic [2:0]  r,
                           input logic [31:0] d,
                           input logic [7:0]  irq = 8'h00);
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b1;
    bus.PADDR   = {27'd0, r, 2'b00};
    bus.PWDATA  = d;
    tick();
    bus.PENABLE = 1'b1;
    irq_i       = irq;
    tick();
    irq_i = '0;
    bus_idle();
  endtask

  task automatic apb_read(input  logic [2:0]  r,
                          output logic [31:0] d,
                          output logic        rdy,
                          input  logic [7:0]  irq = 8'h00);
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
    bus.PADDR   = {27'd0, r, 2'b00};
    tick();
    bus.PENABLE = 1'b1;
    irq_i       = irq;
    #2;
    d   = bus.PRDATA;
    rdy = bus.PREADY;
    @(posedge clk);
    #1;
    irq_i = '0;
    bus_idle();
  endtask

  task automatic pulse(input logic [7:0] m);
    irq_i = m;
    tick();
    irq_i = '0;
  endtask

  task automatic wait_irq(output bit ok);
    int n;
    n = 0;
    while (irq_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    ok = (irq_o === 1'b1);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        rdy;
    do_reset();
    checks++;
    if (irq_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_irq: got %b want 0", irq_o);
    end
    checks++;
    if (bus.PREADY !== 1'b0 || bus.PRDATA !== 32'h0) begin
      failures++;
      $display("FAIL reset_bus: rdy=%b rdata=%h want 0/0",
               bus.PREADY, bus.PRDATA);
    end
    for (int r = 0; r < 4; r++) begin
      apb_read(3'(r), d, rdy);
      checks++;
      if (d !== 32'h0 || rdy !== 1'b1) begin
        failures++;
        $display("FAIL reset_reg%0d: got %h rdy=%b want 0 rdy=1",
                 r, d, rdy);
      end
    end
  endtask

  task automatic test_basic();
    logic [31:0] d;
    logic        rdy;
    do_reset();
    apb_write(R_EN, 32'h01);
    pulse(8'h01);
    checks++;
    if (irq_o !== 1'b0) begin
      failures++;
      $display("FAIL basic_e0: irq=%b want 0", irq_o);
    end
    tick();
    checks++;
    if (irq_o !== 1'b0) begin
      failures++;
      $display("FAIL basic_e1: irq=%b want 0", irq_o);
    end
    tick();
    checks++;
    if (irq_o !== 1'b1) begin
      failures++;
      $display("FAIL basic_e2: irq=%b want 1", irq_o);
    end
    apb_read(R_PEND, d, rdy);
    checks++;
    if (d !== 32'h01) begin
      failures++;
      $display("FAIL basic_pend: got %h want 01", d);
    end
    apb_read(R_CLAIM, d, rdy);
    checks++;
    if (d !== 32'h8000_0000) begin
      failures++;
      $display("FAIL basic_claim: got %h want 80000000", d);
    end
    checks++;
    if (irq_o !== 1'b0) begin
      failures++;
      $display("FAIL basic_irq_low: irq=%b want 0", irq_o);
    end
    apb_read(R_PEND, d, rdy);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL basic_pend_clr: got %h want 0", d);
    end
    apb_read(R_STAT, d, rdy);
    checks++;
    if (d !== 32'h3) begin
      failures++;
      $display("FAIL basic_active: got %h want 3", d);
    end
    apb_write(R_CLAIM, 32'h0);
    apb_read(R_STAT, d, rdy);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL basic_idle: got %h want 0", d);
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] d;
    logic        rdy;
    logic [31:0] id;
    bit          ok;
    do_reset();
    apb_write(R_EN, 32'hFF);
    for (int r = 0; r < 2; r++) begin
      pulse(8'h81);
      for (int k = 0; k < 2; k++) begin
        id = (k == 0) ? 32'd0 : 32'd7;
        wait_irq(ok);
        checks++;
        if (!ok) begin
          failures++;
          $display("FAIL rr_wait%0d_%0d: irq=%b want 1",
                   r, k, irq_o);
        end
        apb_read(R_CLAIM, d, rdy);
        checks++;
        if (d !== (32'h8000_0000 | id)) begin
          failures++;
          $display("FAIL rr_claim%0d_%0d: got %h want %h",
                   r, k, d, 32'h8000_0000 | id);
        end
        apb_write(R_CLAIM, id);
      end
    end
  endtask

  task automatic test_disabled();
    logic [31:0] d;
    logic        rdy;
    bit          ok;
    do_reset();
    pulse(8'h04);
    repeat (4) tick();
    checks++;
    if (irq_o !== 1'b0) begin
      failures++;
      $display("FAIL dis_quiet: irq=%b want 0", irq_o);
    end
    apb_read(R_PEND, d, rdy);
    checks++;
    if (d !== 32'h04) begin
      failures++;
      $display("FAIL dis_pend: got %h want 04", d);
    end
    apb_write(R_EN, 32'h04);
    checks++;
    if (irq_o !== 1'b0) begin
      failures++;
      $display("FAIL dis_ew0: irq=%b want 0", irq_o);
    end
    tick();
    checks++;
    if (irq_o !== 1'b0) begin
      failures++;
      $display("FAIL dis_ew1: irq=%b want 0", irq_o);
    end
    tick();
    checks++;
    if (irq_o !== 1'b1) begin
      failures++;
      $display("FAIL dis_ew2: irq=%b want 1", irq_o);
    end
    apb_read(R_CLAIM, d, rdy);
    checks++;
    if (d !== 32'h8000_0002) begin
      failures++;
      $display("FAIL dis_claim: got %h want 80000002", d);
    end
  endtask

  task automatic test_collision();
    logic [31:0] d;
    logic        rdy;
    bit          ok;
    do_reset();
    pulse(8'h02);
    apb_write(R_PEND, 32'h02, 8'h02);
    apb_read(R_PEND, d, rdy);
    checks++;
    if (d !== 32'h02) begin
      failures++;
      $display("FAIL col_w1c_set: got %h want 02", d);
    end
    apb_write(R_PEND, 32'h02);
    apb_read(R_PEND, d, rdy);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL col_w1c: got %h want 0", d);
    end
    apb_write(R_EN, 32'h02);
    pulse(8'h02);
    wait_irq(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL col_wait: irq=%b want 1", irq_o);
    end
    apb_write(R_EN, 32'h00);
    tick();
    checks++;
    if (irq_o !== 1'b0) begin
      failures++;
      $display("FAIL col_retract: irq=%b want 0", irq_o);
    end
    apb_read(R_STAT, d, rdy);
    checks++;
    if (d !== 32'h04) begin
      failures++;
      $display("FAIL col_stat: got %h want 04", d);
    end
    apb_read(R_CLAIM, d, rdy);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL col_noclaim: got %h want 0", d);
    end
    apb_write(R_EN, 32'h02);
    wait_irq(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL col_wait2: irq=%b want 1", irq_o);
    end
    apb_read(R_CLAIM, d, rdy, 8'h02);
    checks++;
    if (d !== 32'h8000_0001) begin
      failures++;
      $display("FAIL col_claim: got %h want 80000001", d);
    end
    apb_read(R_PEND, d, rdy);
    checks++;
    if (d !== 32'h02) begin
      failures++;
      $display("FAIL col_claim_set: got %h want 02", d);
    end
    apb_write(R_CLAIM, 32'h1);
    wait_irq(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL col_resched: irq=%b want 1", irq_o);
    end
    apb_read(R_CLAIM, d, rdy);
    checks++;
    if (d !== 32'h8000_0001) begin
      failures++;
      $display("FAIL col_claim2: got %h want 80000001", d);
    end
  endtask

  task automatic test_protocol();
    logic [31:0] d;
    logic        rdy;
    bit          ok;
    do_reset();
    apb_write(R_CLAIM, 32'h0);
    apb_read(R_STAT, d, rdy);
    checks++;
    if (d !== 32'h100) begin
      failures++;
      $display("FAIL prot_idle_err: got %h want 100", d);
    end
    apb_write(R_STAT, 32'h100);
    apb_read(R_STAT, d, rdy);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL prot_clr0: got %h want 0", d);
    end
    apb_write(R_EN, 32'h20);
    pulse(8'h20);
    wait_irq(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL prot_wait: irq=%b want 1", irq_o);
    end
    apb_read(R_CLAIM, d, rdy);
    checks++;
    if (d !== 32'h8000_0005) begin
      failures++;
      $display("FAIL prot_claim: got %h want 80000005", d);
    end
    apb_write(R_CLAIM, 32'h3);
    apb_read(R_STAT, d, rdy);
    checks++;
    if (d !== 32'h117) begin
      failures++;
      $display("FAIL prot_bad_id: got %h want 117", d);
    end
    apb_read(R_CLAIM, d, rdy);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL prot_active_rd: got %h want 0", d);
    end
    apb_write(R_STAT, 32'h100);
    apb_read(R_STAT, d, rdy);
    checks++;
    if (d !== 32'h17) begin
      failures++;
      $display("FAIL prot_clr: got %h want 17", d);
    end
    apb_write(R_CLAIM, 32'h5);
    apb_read(R_STAT, d, rdy);
    checks++;
    if (d !== 32'h14) begin
      failures++;
      $display("FAIL prot_done: got %h want 14", d);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    logic        rdy;
    bit          ok;
    do_reset();
    apb_write(R_EN, 32'hFF);
    pulse(8'hF0);
    wait_irq(ok);
    apb_read(R_CLAIM, d, rdy);
    checks++;
    if (!ok || d !== 32'h8000_0004) begin
      failures++;
      $display("FAIL ar_claim: ok=%b got %h want 80000004",
               ok, d);
    end
    pulse(8'hF0);
    apb_read(R_STAT, d, rdy);
    checks++;
    if (d !== 32'h13) begin
      failures++;
      $display("FAIL ar_active: got %h want 13", d);
    end
    apb_write(R_CLAIM, 32'h4);
    wait_irq(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL ar_wait: irq=%b want 1", irq_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (irq_o !== 1'b0) begin
      failures++;
      $display("FAIL ar_async: irq=%b want 0", irq_o);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int r = 0; r < 4; r++) begin
      apb_read(3'(r), d, rdy);
      checks++;
      if (d !== 32'h0) begin
        failures++;
        $display("FAIL ar_reg%0d: got %h want 0", r, d);
      end
    end
    checks++;
    if (irq_o !== 1'b0) begin
      failures++;
      $display("FAIL ar_irq_after: irq=%b want 0", irq_o);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    irq_i = '0;
    bus_idle();
    test_reset();
    test_basic();
    test_round_robin();
    test_disabled();
    test_collision();
    test_protocol();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
